// File: rtl/rfs_uart_pkg.sv
// rtl/rfs_uart_pkg.sv - shared types and constants for the rfs Bluetooth UART receiver
//
// Purpose: receiver FSM state type, register map addresses, STATUS/CTRL bit
//          positions and default parameter values.
// Ports:   none (package).
package rfs_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_e;

   // Register addresses
   localparam logic ADDR_DATA = 1'b0;
   localparam logic ADDR_CSR  = 1'b1;

   // STATUS bit positions
   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_FRAME_ERR = 3;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_COUNT_MSB = 8;
   localparam int STAT_IRQ_EN    = 9;

   // CTRL bit positions
   localparam int CTRL_IRQ_EN    = 0;
   localparam int CTRL_CLR_OVR   = 1;
   localparam int CTRL_CLR_FERR  = 2;

   // 50 MHz / (16 * 27) = 115 740 baud
   localparam int DEFAULT_DIV    = 27;
   localparam int DEFAULT_DEPTH  = 16;

endpackage

// File: rtl/rfs_bt_uart_rx_if.sv
// rtl/rfs_bt_uart_rx_if.sv - Avalon-MM register bus bundle for the UART receiver
//
// Purpose: groups the HPS-facing Avalon-MM slave signals.
// Signals: avs_address (0 = DATA, 1 = STATUS/CTRL), avs_read, avs_write,
//          avs_writedata[31:0], avs_readdata[31:0] (read latency 1).
// Modports: master drives the strobes, slave returns read data.
interface rfs_bt_uart_rx_if;
   import rfs_uart_pkg::*;

   logic        avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );

endinterface

// File: rtl/rfs_uart_fifo.sv
// rtl/rfs_uart_fifo.sv - synchronous FIFO holding received bytes
//
// Purpose: DEPTH x WIDTH first-word-fall-through FIFO. A push while full is
//          accepted only when a pop happens in the same cycle.
// Ports:   clk, reset_n (sync, active-low), push, pop, din[WIDTH-1:0],
//          dout[WIDTH-1:0] (head entry), count (0..DEPTH), full, empty.
module rfs_uart_fifo
   import rfs_uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
      do_pop  = pop && !empty;
      // A full FIFO still takes the push if the head leaves this cycle
      do_push = push && (!full || do_pop);

      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      dout  = mem_q[rd_ptr_q];
      count = count_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/rfs_bt_uart_rx.sv
// rtl/rfs_bt_uart_rx.sv - 8N1 UART receiver with byte FIFO and Avalon-MM access
//
// Purpose: synchronizes rxd, oversamples it 16x, decodes 8N1 frames into a
//          FIFO and exposes DATA / STATUS / CTRL registers plus a level irq.
// Ports:   clk, reset_n (sync, active-low), rxd (async serial in, idles high),
//          avs (Avalon-MM slave bundle), irq (registered irq_en & not_empty).
module rfs_bt_uart_rx
   import rfs_uart_pkg::*;
#(
   parameter int DIV   = DEFAULT_DIV,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               rxd,
   rfs_bt_uart_rx_if.slave    avs,
   output logic               irq
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   // ---------------------------------------------------------------- sync
   logic rxd_meta_q, rxs_q;

   // Both stages reset high so a reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rxd_meta_q <= 1'b1;
         rxs_q      <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxs_q      <= rxd_meta_q;
      end
   end

   // ---------------------------------------------------------------- tick
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic          tick;

   always_comb begin
      tick      = (div_cnt_q == DW'(DIV - 1));
      div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   // ---------------------------------------------------------------- FSM
   rx_state_e  state_q;
   logic [3:0] tc_q;
   logic [2:0] bi_q;
   logic [7:0] shift_q;
   logic       rx_push_q;
   logic       ferr_set_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         tc_q       <= '0;
         bi_q       <= '0;
         shift_q    <= '0;
         rx_push_q  <= 1'b0;
         ferr_set_q <= 1'b0;
      end else begin
         rx_push_q  <= 1'b0;
         ferr_set_q <= 1'b0;
         if (tick) begin
            case (state_q)
               ST_IDLE: begin
                  if (!rxs_q) begin
                     state_q <= ST_START;
                     tc_q    <= '0;
                  end
               end
               ST_START: begin
                  // Eighth tick lands mid start bit; a high line here was a glitch
                  if (tc_q == 4'd7) begin
                     tc_q <= '0;
                     bi_q <= '0;
                     state_q <= rxs_q ? ST_IDLE : ST_DATA;
                  end else begin
                     tc_q <= tc_q + 4'd1;
                  end
               end
               ST_DATA: begin
                  if (tc_q == 4'd15) begin
                     tc_q    <= '0;
                     shift_q <= {rxs_q, shift_q[7:1]};
                     if (bi_q == 3'd7) begin
                        state_q <= ST_STOP;
                     end else begin
                        bi_q <= bi_q + 3'd1;
                     end
                  end else begin
                     tc_q <= tc_q + 4'd1;
                  end
               end
               ST_STOP: begin
                  if (tc_q == 4'd15) begin
                     tc_q <= '0;
                     if (rxs_q) begin
                        rx_push_q <= 1'b1;
                        state_q   <= ST_IDLE;
                     end else begin
                        ferr_set_q <= 1'b1;
                        state_q    <= ST_WAIT_HIGH;
                     end
                  end else begin
                     tc_q <= tc_q + 4'd1;
                  end
               end
               ST_WAIT_HIGH: begin
                  // Stay out of IDLE until the line recovers, else a held-low
                  // line would be decoded as a stream of 0x00 frames
                  if (rxs_q) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty, fifo_pop;

   rfs_uart_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_push_q),
      .pop     (fifo_pop),
      .din     (shift_q),
      .dout    (fifo_dout),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // ---------------------------------------------------------------- registers
   logic [31:0] readdata_q, readdata_d;
   logic        irq_en_q, irq_en_d;
   logic        ovr_q, ovr_d;
   logic        ferr_q, ferr_d;
   logic        irq_q, irq_d;
   logic [31:0] status_word;
   logic        csr_wr, ovr_set;
   logic        unused_wdata;

   assign unused_wdata = ^avs.avs_writedata[31:3];

   always_comb begin
      status_word                                = '0;
      status_word[STAT_NOT_EMPTY]                = !fifo_empty;
      status_word[STAT_FULL]                     = fifo_full;
      status_word[STAT_OVERRUN]                  = ovr_q;
      status_word[STAT_FRAME_ERR]                = ferr_q;
      status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 5'(fifo_count);
      status_word[STAT_IRQ_EN]                   = irq_en_q;

      fifo_pop = avs.avs_read && (avs.avs_address == ADDR_DATA) && !fifo_empty;
      csr_wr   = avs.avs_write && (avs.avs_address == ADDR_CSR);

      readdata_d = readdata_q;
      if (avs.avs_read) begin
         if (avs.avs_address == ADDR_DATA) begin
            readdata_d = fifo_empty ? 32'd0 : {23'd0, 1'b1, fifo_dout};
         end else begin
            readdata_d = status_word;
         end
      end

      irq_en_d = csr_wr ? avs.avs_writedata[CTRL_IRQ_EN] : irq_en_q;

      // Clear first, then set, so a coincident set wins
      ovr_set = rx_push_q && fifo_full && !fifo_pop;
      ovr_d   = ovr_q;
      if (csr_wr && avs.avs_writedata[CTRL_CLR_OVR]) ovr_d = 1'b0;
      if (ovr_set) ovr_d = 1'b1;

      ferr_d = ferr_q;
      if (csr_wr && avs.avs_writedata[CTRL_CLR_FERR]) ferr_d = 1'b0;
      if (ferr_set_q) ferr_d = 1'b1;

      irq_d = irq_en_q && !fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata_q <= '0;
         irq_en_q   <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         readdata_q <= readdata_d;
         irq_en_q   <= irq_en_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         irq_q      <= irq_d;
      end
   end

   assign avs.avs_readdata = readdata_q;
   assign irq              = irq_q;

endmodule

// File: tb/tb_rfs_bt_uart_rx.sv
// tb/tb_rfs_bt_uart_rx.sv - self-checking bench for rfs_bt_uart_rx
module tb_rfs_bt_uart_rx;
   import rfs_uart_pkg::*;

   localparam int DIV   = 4;
   localparam int DEPTH = 16;
   localparam int BIT   = 16 * DIV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rxd = 1'b1;
   logic irq;

   rfs_bt_uart_rx_if avs_if ();

   rfs_bt_uart_rx #(
      .DIV   (DIV),
      .DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rxd     (rxd),
      .avs     (avs_if),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: what the HPS should see
   byte unsigned mq[$];
   bit m_ovr, m_ferr, m_irq_en;

   function automatic void model_rx(input byte unsigned b);
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovr = 1'b1;
   endfunction

   function automatic logic [31:0] model_pop();
      byte unsigned b;
      if (mq.size() == 0) return 32'd0;
      b = mq.pop_front();
      return {23'd0, 1'b1, b};
   endfunction

   function automatic logic [31:0] model_status();
      logic [4:0] c;
      c = 5'(mq.size());
      return {22'd0, m_irq_en, c, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
   endfunction

   function automatic void model_ctrl(input logic [31:0] wd);
      m_irq_en = wd[0];
      if (wd[1]) m_ovr = 1'b0;
      if (wd[2]) m_ferr = 1'b0;
   endfunction

   function automatic void model_clear();
      mq.delete();
      m_ovr = 0;
      m_ferr = 0;
      m_irq_en = 0;
   endfunction

   // All tasks start and end on a falling edge
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic bus_read(input logic addr, output logic [31:0] d);
      avs_if.avs_address = addr;
      avs_if.avs_read    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      avs_if.avs_read = 1'b0;
      d = avs_if.avs_readdata;
   endtask

   task automatic bus_write(input logic addr, input logic [31:0] wd);
      avs_if.avs_address   = addr;
      avs_if.avs_writedata = wd;
      avs_if.avs_write     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      avs_if.avs_write = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset_n = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (avs_if.avs_readdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_readdata: got %h expected %h", avs_if.avs_readdata, 32'd0);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
      reset_n = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL reset_status: got %h expected %h", d, model_status());
      end
   endtask

   task automatic test_single_byte();
      logic [31:0] d, e;
      send_frame(8'h55, 1'b1);
      model_rx(8'h55);
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status() || d !== 32'h011) begin
         errors++;
         $display("FAIL single_status: got %h expected %h", d, model_status());
      end
      bus_read(ADDR_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL single_data: got %h expected %h", d, e);
      end
      bus_read(ADDR_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL single_empty_read: got %h expected %h", d, e);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d, e;
      rxd = 1'b0;
      repeat (4 * DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL glitch_status: got %h expected %h", d, model_status());
      end
      send_frame(8'hA3, 1'b1);
      model_rx(8'hA3);
      bus_read(ADDR_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL glitch_next_byte: got %h expected %h", d, e);
      end
   endtask

   task automatic test_framing();
      logic [31:0] d, e;
      send_frame(8'hA3, 1'b0);
      m_ferr = 1'b1;
      repeat (BIT) @(negedge clk);
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL ferr_status: got %h expected %h", d, model_status());
      end
      send_frame(8'h3C, 1'b1);
      model_rx(8'h3C);
      bus_read(ADDR_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL ferr_recover_data: got %h expected %h", d, e);
      end
      bus_write(ADDR_CSR, 32'h4);
      model_ctrl(32'h4);
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL ferr_clear_status: got %h expected %h", d, model_status());
      end
   endtask

   task automatic test_random_stream();
      logic [31:0] d, e;
      logic [7:0]  b;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b1);
         model_rx(b);
         repeat ($urandom_range(0, BIT)) @(negedge clk);
      end
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL stream_status: got %h expected %h", d, model_status());
      end
      for (int i = 0; i < 7; i++) begin
         bus_read(ADDR_DATA, d);
         e = model_pop();
         checks++;
         if (d !== e) begin
            errors++;
            $display("FAIL stream_data[%0d]: got %h expected %h", i, d, e);
         end
      end
   endtask

   task automatic test_overrun();
      logic [31:0] d, e;
      for (int i = 0; i <= 16; i++) begin
         send_frame(8'(i), 1'b1);
         model_rx(8'(i));
      end
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL overrun_status: got %h expected %h", d, model_status());
      end
      for (int i = 0; i < 17; i++) begin
         bus_read(ADDR_DATA, d);
         e = model_pop();
         checks++;
         if (d !== e) begin
            errors++;
            $display("FAIL overrun_data[%0d]: got %h expected %h", i, d, e);
         end
      end
      bus_write(ADDR_CSR, 32'h2);
      model_ctrl(32'h2);
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL overrun_clear_status: got %h expected %h", d, model_status());
      end
   endtask

   task automatic test_interrupt();
      logic [31:0] d, e;
      logic [7:0]  b;
      bit          hit;
      bus_write(ADDR_CSR, 32'h1);
      model_ctrl(32'h1);
      send_frame(8'h7E, 1'b1);
      model_rx(8'h7E);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_assert: got %b expected 1", irq);
      end
      bus_read(ADDR_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL irq_data: got %h expected %h", d, e);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_deassert: got %b expected 0", irq);
      end

      // Fill, then pop exactly as the 17th byte lands
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b1);
         model_rx(b);
      end
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL full_status: got %h expected %h", d, model_status());
      end
      b = 8'($urandom_range(0, 255));
      hit = 0;
      d = '0;
      fork
         send_frame(b, 1'b1);
         begin
            for (int k = 0; k < 12 * BIT; k++) begin
               @(negedge clk);
               if (dut.rx_push_q) begin
                  hit = 1;
                  break;
               end
            end
            if (hit) bus_read(ADDR_DATA, d);
         end
      join
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL push_pop_timeout: got no push expected push within %0d cycles", 12 * BIT);
      end else begin
         e = model_pop();
         model_rx(b);
         checks++;
         if (d !== e) begin
            errors++;
            $display("FAIL push_pop_data: got %h expected %h", d, e);
         end
      end
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL push_pop_status: got %h expected %h", d, model_status());
      end
      while (mq.size() != 0) begin
         bus_read(ADDR_DATA, d);
         e = model_pop();
         checks++;
         if (d !== e) begin
            errors++;
            $display("FAIL push_pop_drain: got %h expected %h", d, e);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d, e;
      logic [7:0]  b;
      send_frame(8'h5A, 1'b1);
      model_rx(8'h5A);
      repeat (2) @(negedge clk);
      checks++;
      if (irq !== (m_irq_en && mq.size() != 0)) begin
         errors++;
         $display("FAIL prereset_irq: got %b expected %b", irq, (m_irq_en && mq.size() != 0));
      end
      b = 8'hC9;
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = b[3];
      repeat (BIT / 2) @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (avs_if.avs_readdata !== 32'd0) begin
         errors++;
         $display("FAIL midreset_readdata: got %h expected %h", avs_if.avs_readdata, 32'd0);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_irq: got %b expected 0", irq);
      end
      reset_n = 1'b1;
      rxd = 1'b1;
      model_clear();
      @(negedge clk);
      bus_read(ADDR_CSR, d);
      checks++;
      if (d !== model_status()) begin
         errors++;
         $display("FAIL midreset_status: got %h expected %h", d, model_status());
      end
      repeat (10 * BIT) @(negedge clk);
      send_frame(b, 1'b1);
      model_rx(b);
      bus_read(ADDR_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e || d !== 32'h1C9) begin
         errors++;
         $display("FAIL midreset_next_byte: got %h expected %h", d, e);
      end
   endtask

   initial begin
      avs_if.avs_address   = 1'b0;
      avs_if.avs_read      = 1'b0;
      avs_if.avs_write     = 1'b0;
      avs_if.avs_writedata = '0;
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_glitch();
      test_framing();
      test_random_stream();
      test_overrun();
      test_interrupt();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got no finish expected finish within 90000 cycles");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rfs_bt_uart_rx.md
# rfs_bt_uart_rx

UART receiver for the Bluetooth module on the `rfs` peripheral. It takes the serial line from the module's TX pin (wired to `GPIO_0[18]` at top level), oversamples it 16x, and decodes 8N1 frames. Decoded bytes go into a 16-entry FIFO that the HPS reads over an Avalon-MM slave. A level interrupt signals that bytes are waiting.

## Interface
- `DIV`, default 27: system clocks per oversample tick. The bit rate is clk/(16·DIV), so 50 MHz gives 115 740 baud (0.47 % error).
- `DEPTH`, default 16: FIFO depth. Must be a power of two.
- `clk`, in, 1: system clock, 50 MHz.
- `reset_n`, in, 1: one clock domain; reset is synchronous and active-low.
- `rxd`, in, 1: asynchronous serial input. Idles high.
- `avs_address`, in, 1: 0 = DATA, 1 = STATUS/CTRL.
- `avs_read`, in, 1: read strobe.
- `avs_write`, in, 1: write strobe.
- `avs_writedata`, in, 32: write data.
- `avs_readdata`, out, 32: read data. Read latency is 1.
- `irq`, out, 1: level interrupt, registered.

## Operation
- **Input synchronizer:** `rxd` passes through 2 flops, both reset to 1. All decoding uses the synchronized signal `rxs`.
- **Tick generator:** free-running counter 0..DIV-1, resets to 0. `tick` pulses for one cycle when the count is DIV-1.
- **FSM:** states IDLE, START, DATA, STOP, WAIT_HIGH; reset state is IDLE. Tick count `tc` is 4 bits, bit index `bi` is 3 bits. Outside IDLE, every step below happens only on `tick`.
  - IDLE: on `tick` with `rxs`=0, go to START with `tc`=0.
  - START: on the 8th tick (mid start bit), if `rxs`=0 go to DATA with `tc`=0 and `bi`=0. Otherwise go to IDLE; this is a glitch and is discarded.
  - DATA: on every 16th tick, shift `rxs` into the shift register, LSB first. After `bi`=7, go to STOP.
  - STOP: on the 16th tick, sample `rxs`.
    - If 1: push the byte and go to IDLE.
    - If 0: set FRAME_ERR, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: on `tick` with `rxs`=1, go to IDLE.
- **Push when full:** the byte is dropped and OVERRUN is set. If a pop happens in the same cycle, the push succeeds.
- **DATA read (address 0):**
  - Returns {23'b0, valid, byte}. `valid` is 1 when the FIFO was non-empty.
  - A non-empty read pops one entry.
  - An empty read returns 0 and has no side effects.
- **STATUS read (address 1):**
  - Bit 0: not_empty.
  - Bit 1: full.
  - Bit 2: OVERRUN.
  - Bit 3: FRAME_ERR.
  - Bits [8:4]: count, 0..16.
  - Bit 9: irq_en.
  - All other bits read 0.
- **CTRL write (address 1):**
  - Bit 0 → irq_en.
  - Bit 1 = 1 clears OVERRUN.
  - Bit 2 = 1 clears FRAME_ERR.
  - Writes to address 0 are ignored.
- **Flag precedence:** if a flag is set and cleared in the same cycle, set wins.
- **Interrupt:** `irq` is registered as `irq_en & not_empty`.
- **Simultaneous push and pop:** both are performed and the count is unchanged.

## Timing
- **Reset values:** `avs_readdata`=0, `irq`=0, irq_en=0, flags 0, FIFO empty. Reset is honoured mid-frame: the FSM returns to IDLE and the partial byte is lost.
- **Read latency:** `avs_readdata` is valid the cycle after `avs_read`. A pop takes effect in that same cycle, so STATUS is updated for any read issued in the following cycle.
- **Receive latency:** a byte is in the FIFO (not_empty=1) the cycle after the mid-stop-bit tick. That is about 9.5 bit times plus 2 to 3 clocks after the falling edge of the start bit.
- **Interrupt latency:** `irq` follows not_empty and irq_en with a 1-cycle lag.
- **Sampling tolerance:** start detection has a jitter of up to 1 tick (DIV clocks). Sampling is at bit centre ±1/16 bit.

## Structure
- **Package `rfs_uart_pkg`:**
  - FSM state enum.
  - Register address constants.
  - STATUS/CTRL bit-position localparams.
  - Default DIV.
- **Sub-module `rfs_uart_fifo`:** synchronous FIFO with DEPTH and WIDTH parameters.
  - Ports: push, pop, din, dout, count, full, empty.
  - Pointers wrap modulo DEPTH.
  - Count is $clog2(DEPTH)+1 bits.
- **Top-level integration:** `rfs_bt_uart_rx` instantiates the FIFO. It is the mirror of the existing `rfs_bt_uart_txd` path.

## Test plan
- **Single byte:** drive 0x55 at 16·27 clk/bit → STATUS = 0x011. DATA read → 0x155. Second DATA read → 0x000.
- **Start glitch:** hold `rxd` low for 4·27 clocks → no push, FSM returns to IDLE. A following 0xA3 frame is received as 0x1A3.
- **Framing error:** send 0xA3 with stop bit 0 → STATUS bit 3 = 1, count 0. Raise the line, send 0x3C → read 0x13C. Write 0x4 to address 1 → bit 3 clears.
- **Overrun:** send 0x00..0x10 (17 bytes) with no reads → count 16, full=1, OVERRUN=1. Reads return 0x100..0x10F; 0x10 is lost.
- **Interrupt:** write 0x1 to address 1, receive 0x7E → `irq`=1. DATA read → `irq`=0 by 2 cycles after the read. Push and pop in the same cycle with count 16 → count stays 16, no OVERRUN.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 3 → `avs_readdata`=0, `irq`=0, FIFO empty. After 10 idle bit times, 0xC9 is received as 0x1C9.
